// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I field-to-word encoder with range checks and word-address tagging
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_format,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [2:0]        out_err_code,
    output logic              wrapped
);
    localparam logic [2:0] F_U = 3'd0, F_J = 3'd1, F_B = 3'd2, F_I = 3'd3, F_S = 3'd4, F_R = 3'd5;
    logic              s1_valid, s1_advance;
    logic [2:0]        s1_format, s1_funct3, s1_code;
    logic [6:0]        s1_opcode, s1_funct7;
    logic [4:0]        s1_rd, s1_rs1, s1_rs2;
    logic [31:0]       s1_imm, s1_instr;
    logic [ADDR_W-1:0] addr;
    logic              ok12, ok13, ok21, misal, range_bad;
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_addr   = addr;
    // sign-extension checks: the bits above the field's sign bit must all match it
    assign ok12 = &s1_imm[31:11] | ~|s1_imm[31:11];
    assign ok13 = &s1_imm[31:12] | ~|s1_imm[31:12];
    assign ok21 = &s1_imm[31:20] | ~|s1_imm[31:20];
    assign misal = ((s1_format == F_B || s1_format == F_J) && s1_imm[0])
                || (s1_format == F_U && |s1_imm[11:0]);
    assign range_bad = ((s1_format == F_I || s1_format == F_S) && !ok12)
                    || (s1_format == F_B && !ok13)
                    || (s1_format == F_J && !ok21);
    assign s1_code = s1_format > F_R ? 3'd1 :
                     s1_opcode[1:0] != 2'b11 ? 3'd4 :
                     misal ? 3'd3 :
                     range_bad ? 3'd2 : 3'd0;
    always_comb begin
        s1_instr = '0;
        case (s1_format)
            F_R: s1_instr = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            F_I: s1_instr = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            F_S: s1_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            F_B: s1_instr = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:1], s1_imm[11], s1_opcode};
            F_U: s1_instr = {s1_imm[31:12], s1_rd, s1_opcode};
            F_J: s1_instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
            default: s1_instr = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_err      <= 1'b0;
            out_err_code <= '0;
            addr         <= ADDR_W'(BASE_ADDR);
            wrapped      <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_format <= in_format;
                s1_opcode <= in_opcode;
                s1_rd     <= in_rd;
                s1_rs1    <= in_rs1;
                s1_rs2    <= in_rs2;
                s1_funct3 <= in_funct3;
                s1_funct7 <= in_funct7;
                s1_imm    <= in_imm;
            end
            if (s1_advance) out_valid <= s1_valid;
            if (s1_advance && s1_valid) begin
                out_instr    <= s1_code != 3'd0 ? 32'h0 : s1_instr;
                out_err      <= s1_code != 3'd0;
                out_err_code <= s1_code;
            end
            // error records keep their address so the next good word reuses it
            if (out_valid && out_ready && !out_err) begin
                addr <= addr + ADDR_W'(1);
                if (&addr) wrapped <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a field-level reference model
module tb_instr_encoder;
    typedef struct packed {logic [31:0] instr; logic err; logic [2:0] code;} rec_t;
    typedef struct packed {logic [31:0] instr; logic [9:0] addr; logic [2:0] code;} gold_t;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, out_ready = 0;
    logic [2:0]  in_format = 0, in_funct3 = 0;
    logic [6:0]  in_opcode = 0, in_funct7 = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [31:0] in_imm = 0;
    logic        in_ready, out_valid, out_err, wrapped;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic [2:0]  out_err_code;
    logic        s_in_ready, s_out_valid, s_out_err, s_wrapped;
    logic [31:0] s_out_instr;
    logic [1:0]  s_out_addr;
    logic [2:0]  s_out_err_code;
    int vectors = 0, miscompares = 0;
    rec_t q[$];
    gold_t gold[$];
    int cnt10, cnt2, out_cnt, idx;
    bit wrap10, wrap2, held, accepted;
    logic [31:0] h_instr;
    logic [9:0]  h_addr;
    logic [2:0]  h_code;
    int edges[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 1048574, 1048576, -1048576, -1048578};
    always #5 clk = ~clk;
    instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .out_err_code(out_err_code), .wrapped(wrapped)
    );
    instr_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_addr(s_out_addr),
        .out_err(s_out_err), .out_err_code(s_out_err_code), .wrapped(s_wrapped)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    function automatic rec_t model();
        rec_t r;
        logic signed [31:0] s;
        logic [31:0] u, op, rd, rs1, rs2, f3, f7;
        s = in_imm;
        u = in_imm;
        op = 32'(in_opcode);
        rd = 32'(in_rd) << 7;
        rs1 = 32'(in_rs1) << 15;
        rs2 = 32'(in_rs2) << 20;
        f3 = 32'(in_funct3) << 12;
        f7 = 32'(in_funct7) << 25;
        r = '0;
        if (in_format > 5) r.code = 1;
        else if (op % 4 != 3) r.code = 4;
        else if ((in_format == 2 || in_format == 1) && u % 2 != 0) r.code = 3;
        else if (in_format == 0 && u % 4096 != 0) r.code = 3;
        else if ((in_format == 3 || in_format == 4) && (s < -2048 || s > 2047)) r.code = 2;
        else if (in_format == 2 && (s < -4096 || s > 4095)) r.code = 2;
        else if (in_format == 1 && (s < -1048576 || s > 1048575)) r.code = 2;
        r.err = r.code != 0;
        if (!r.err)
            case (in_format)
                5: r.instr = f7 | rs2 | rs1 | f3 | rd | op;
                3: r.instr = (u % 4096) << 20 | rs1 | f3 | rd | op;
                4: r.instr = ((u >> 5) % 128) << 25 | rs2 | rs1 | f3 | (u % 32) << 7 | op;
                2: r.instr = ((u >> 12) % 2) << 31 | ((u >> 5) % 64) << 25 | rs2 | rs1 | f3
                           | ((u >> 1) % 16) << 8 | ((u >> 11) % 2) << 7 | op;
                0: r.instr = (u >> 12) << 12 | rd | op;
                default: r.instr = ((u >> 20) % 2) << 31 | ((u >> 1) % 1024) << 21 | ((u >> 11) % 2) << 20
                                 | ((u >> 12) % 256) << 12 | rd | op;
            endcase
        return r;
    endfunction
    task automatic step();
        rec_t r;
        gold_t g;
        #1;
        chk("wrapped", wrapped, wrap10);
        chk("s_wrapped", s_wrapped, wrap2);
        if (held) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_instr", out_instr, h_instr);
            chk("hold_addr", out_addr, h_addr);
            chk("hold_code", out_err_code, h_code);
        end
        held = out_valid && !out_ready;
        h_instr = out_instr;
        h_addr = out_addr;
        h_code = out_err_code;
        if (out_valid && out_ready) begin
            out_cnt++;
            chk("expected_out", q.size() > 0, 1);
            if (q.size() > 0) begin
                r = q.pop_front();
                chk("instr", out_instr, r.instr);
                chk("err", out_err, r.err);
                chk("code", out_err_code, r.code);
                chk("addr", out_addr, cnt10);
                chk("s_addr", s_out_addr, cnt2);
                if (!r.err) begin
                    if (cnt10 == 1023) wrap10 = 1;
                    if (cnt2 == 3) wrap2 = 1;
                    cnt10 = (cnt10 + 1) % 1024;
                    cnt2 = (cnt2 + 1) % 4;
                end
            end
            if (gold.size() > 0) begin
                g = gold.pop_front();
                chk("gold_instr", out_instr, g.instr);
                chk("gold_addr", out_addr, g.addr);
                chk("gold_code", out_err_code, g.code);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(model());
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        in_valid = 1;
        in_format = f;
        in_opcode = op;
        in_rd = rd;
        in_rs1 = rs1;
        in_rs2 = rs2;
        in_funct3 = f3;
        in_funct7 = 0;
        in_imm = imm;
    endtask
    task automatic expect_gold(input logic [31:0] instr, input logic [9:0] addr, input logic [2:0] code);
        gold.push_back(gold_t'{instr, addr, code});
    endtask
    task automatic do_reset();
        rst = 1;
        in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        q.delete();
        gold.delete();
        cnt10 = 0;
        cnt2 = 0;
        wrap10 = 0;
        wrap2 = 0;
        held = 0;
    endtask
    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drained", q.size(), 0);
        chk("gold_left", gold.size(), 0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_code", out_err_code, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_addr", out_addr, 0);
        // addi x1,x0,5 and its two-edge latency
        out_ready = 1;
        expect_gold(32'h00500093, 0, 0);
        drive(3, 7'b0010011, 1, 0, 0, 0, 5);
        step();
        in_valid = 0;
        chk("lat_edge1", out_valid, 0);
        step();
        chk("lat_edge2", out_valid, 1);
        drain();
        // back-to-back S, B, J, U
        do_reset();
        out_ready = 1;
        expect_gold(32'h0020A423, 0, 0);
        expect_gold(32'hFE000EE3, 1, 0);
        expect_gold(32'h001000EF, 2, 0);
        expect_gold(32'h123452B7, 3, 0);
        drive(4, 7'b0100011, 0, 1, 2, 2, 8);
        step();
        drive(2, 7'b1100011, 0, 0, 0, 0, 32'hFFFFFFFC);
        step();
        drive(1, 7'b1101111, 1, 0, 0, 0, 2048);
        step();
        drive(0, 7'b0110111, 5, 0, 0, 0, 32'h12345000);
        step();
        in_valid = 0;
        step();
        step();
        chk("b2b_consecutive", gold.size(), 0);
        drain();
        // error records keep the address
        do_reset();
        out_ready = 1;
        expect_gold(0, 0, 2);
        expect_gold(0, 0, 3);
        expect_gold(0, 0, 1);
        expect_gold(0, 0, 4);
        expect_gold(32'h00500093, 0, 0);
        drive(3, 7'b0010011, 1, 0, 0, 0, 2048);
        step();
        drive(2, 7'b1100011, 0, 0, 0, 0, 3);
        step();
        drive(7, 7'b0010011, 1, 0, 0, 0, 5);
        step();
        drive(3, 7'b0010010, 1, 0, 0, 0, 5);
        step();
        drive(3, 7'b0010011, 1, 0, 0, 0, 5);
        step();
        drain();
        // backpressure: only two records fit
        do_reset();
        out_ready = 0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 4) drive(3, 7'b0010011, 5'(idx + 1), 0, 0, 0, 32'(idx));
            else in_valid = 0;
            step();
            if (accepted) idx++;
        end
        chk("bp_accepts", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1;
        out_cnt = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            drive(3, 7'b0010011, 5'(idx + 1), 0, 0, 0, 32'(idx));
            step();
            if (accepted) idx++;
        end
        drain();
        chk("bp_count", out_cnt, 4);
        // two-bit counter wraps after four good words
        do_reset();
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            drive(3, 7'b0010011, 5'(k), 0, 0, 0, 32'(k));
            step();
        end
        drain();
        chk("wrap_flag", s_wrapped, 1);
        chk("wrap_addr", s_out_addr, 1);
        chk("big_no_wrap", wrapped, 0);
        // reset with both stages full
        out_ready = 0;
        drive(3, 7'b0010011, 1, 0, 0, 0, 1);
        step();
        drive(3, 7'b0010011, 2, 0, 0, 0, 2);
        step();
        chk("full_in_ready", in_ready, 0);
        do_reset();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_addr", out_addr, 0);
        chk("flush_s_addr", s_out_addr, 0);
        chk("flush_wrapped", s_wrapped, 0);
        out_ready = 1;
        out_cnt = 0;
        repeat (4) step();
        chk("flush_no_ghost", out_cnt, 0);
        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            out_ready = $urandom % 4 != 0;
            in_valid = $urandom % 4 != 0;
            in_format = ($urandom % 8 == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            in_opcode = 7'($urandom);
            if ($urandom % 8 != 0) in_opcode[1:0] = 2'b11;
            in_rd = 5'($urandom);
            in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom);
            in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            case ($urandom % 5)
                0: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: in_imm = $urandom & 32'hFFFFF000;
                2: in_imm = $urandom;
                3: in_imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
                default: in_imm = edges[$urandom % 12];
            endcase
            step();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
